// File: rtl/poly_add_pkg.sv
// Shared constants, sizing helpers and FSM state type for the sequential modular
// polynomial adder.
package poly_add_pkg;

    localparam int Q = 3329;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_U = 2'd1,
        RUN_V = 2'd2
    } state_t;

    function automatic int beats(input int n, input int lanes);
        return n / lanes;
    endfunction

    // Two guard bits cover the signed noise and the three-operand carry.
    function automatic int sum_width(input int coef_w);
        return coef_w + 2;
    endfunction

endpackage

// File: rtl/poly_add_seq_mod_add3.sv
// One lane of the shared adder bank: a + sext(e) [+ b], folded back into [0, Q)
// by a single conditional correction.
module mod_add3
    import poly_add_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int E_W    = 4
) (
    input  logic [COEF_W-1:0]        a,
    input  logic [COEF_W-1:0]        b,
    input  logic signed [E_W-1:0]    e,
    input  logic                     c_en,
    output logic [COEF_W-1:0]        sum,
    output logic                     out_of_range
);

    localparam int SW = sum_width(COEF_W);
    localparam logic signed [SW-1:0] Q_S  = SW'(Q);
    localparam logic signed [SW-1:0] Q2_S = SW'(2 * Q);

    function automatic logic signed [SW-1:0] reduce(input logic signed [SW-1:0] s);
        if (s < 0)
            return s + Q_S;
        else if (s >= Q2_S)
            return s - Q2_S;
        else if (s >= Q_S)
            return s - Q_S;
        else
            return s;
    endfunction

    logic signed [SW-1:0] a_s;
    logic signed [SW-1:0] b_s;
    logic signed [SW-1:0] e_s;
    logic signed [SW-1:0] raw;
    logic signed [SW-1:0] red;

    always_comb begin
        a_s = $signed({2'b00, a});
        b_s = c_en ? $signed({2'b00, b}) : '0;
        e_s = {{(SW-E_W){e[E_W-1]}}, e};
        raw = a_s + b_s + e_s;
        red = reduce(raw);
        sum = red[COEF_W-1:0];
        out_of_range = (a >= COEF_W'(Q)) || (c_en && (b >= COEF_W'(Q)));
    end

endmodule

// File: rtl/poly_add_seq.sv
// Time-multiplexed mod-Q adder: u[i] = x[i] + e_1[i] for i < k, then
// v = y + e_2 + msg_poly, LANES coefficients per cycle.
module poly_add_seq
    import poly_add_pkg::*;
#(
    parameter int N      = 256,
    parameter int KMAX   = 4,
    parameter int LANES  = 16,
    parameter int COEF_W = 16,
    parameter int E_W    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [2:0]                          k_sel,
    input  logic [KMAX-1:0][N*COEF_W-1:0]       x,
    input  logic [N*COEF_W-1:0]                 y,
    input  logic [N*COEF_W-1:0]                 msg_poly,
    input  logic [KMAX-1:0][N*E_W-1:0]          e_1,
    input  logic [N*E_W-1:0]                    e_2,
    output logic [KMAX-1:0][N*COEF_W-1:0]       u,
    output logic [N*COEF_W-1:0]                 v,
    output logic                                busy,
    output logic                                done,
    output logic                                cfg_err,
    output logic                                coef_err
);

    localparam int BEATS = beats(N, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (KMAX > 1) ? $clog2(KMAX) : 1;

    state_t            state;
    logic [PW-1:0]     p;
    logic [BW-1:0]     b;
    logic [2:0]        k_r;

    logic [COEF_W-1:0]        op_a [LANES];
    logic [COEF_W-1:0]        op_b [LANES];
    logic signed [E_W-1:0]    op_e [LANES];
    logic [COEF_W-1:0]        res  [LANES];
    logic [LANES-1:0]         oor;
    logic                     run_v;
    logic                     last_beat;
    logic                     k_legal;

    always_comb begin
        run_v     = (state == RUN_V);
        last_beat = (b == BW'(BEATS - 1));
        k_legal   = (k_sel >= 3'd2) && (int'(k_sel) <= KMAX);
        for (int j = 0; j < LANES; j++) begin
            op_a[j] = run_v ? y[(int'(b)*LANES + j)*COEF_W +: COEF_W]
                            : x[p][(int'(b)*LANES + j)*COEF_W +: COEF_W];
            op_b[j] = msg_poly[(int'(b)*LANES + j)*COEF_W +: COEF_W];
            op_e[j] = run_v ? $signed(e_2[(int'(b)*LANES + j)*E_W +: E_W])
                            : $signed(e_1[p][(int'(b)*LANES + j)*E_W +: E_W]);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mod_add3 #(
            .COEF_W (COEF_W),
            .E_W    (E_W)
        ) u_lane (
            .a            (op_a[g]),
            .b            (op_b[g]),
            .e            (op_e[g]),
            .c_en         (run_v),
            .sum          (res[g]),
            .out_of_range (oor[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            p        <= '0;
            b        <= '0;
            k_r      <= '0;
            u        <= '0;
            v        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            coef_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (k_legal) begin
                            k_r      <= k_sel;
                            coef_err <= 1'b0;
                            busy     <= 1'b1;
                            p        <= '0;
                            b        <= '0;
                            state    <= RUN_U;
                            // Ranks above k are never visited, so clear them now.
                            for (int i = 0; i < KMAX; i++)
                                if (i >= int'(k_sel))
                                    u[i] <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN_U: begin
                    for (int j = 0; j < LANES; j++)
                        u[p][(int'(b)*LANES + j)*COEF_W +: COEF_W] <= res[j];
                    if (|oor)
                        coef_err <= 1'b1;
                    b <= b + 1'b1;
                    if (last_beat) begin
                        b <= '0;
                        if (int'(p) == int'(k_r) - 1)
                            state <= RUN_V;
                        else
                            p <= p + 1'b1;
                    end
                end
                RUN_V: begin
                    for (int j = 0; j < LANES; j++)
                        v[(int'(b)*LANES + j)*COEF_W +: COEF_W] <= res[j];
                    if (|oor)
                        coef_err <= 1'b1;
                    b <= b + 1'b1;
                    if (last_beat) begin
                        b     <= '0;
                        p     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/poly_add_seq.md
Name: poly_add_seq

Overview:
- Sequential modular polynomial adder for the Kyber encryption path. Computes u[i] = (x[i] + e_1[i]) mod Q for i < k and v = (y + e_2 + msg_poly) mod Q.
- Uses a shared bank of LANES reducing adders, time-multiplexed over k+1 polynomial rounds.
- Generalises the fixed rank-3, unreduced adder stage: runtime rank, configurable lane count, full mod-Q reduction, signed noise, and a start/busy/done handshake.
- Sits between the NTT-domain multiply/INTT outputs and the compress stage.

Parameters:
- N, 256, coefficients per polynomial.
- Q, 3329, modulus.
- KMAX, 4, maximum module rank; sizes the u/x/e_1 arrays.
- LANES, 16, coefficients processed per cycle; power of 2 that divides N.
- COEF_W, 16, container width of x/y/msg/u/v coefficients (low 12 bits significant).
- E_W, 4, two's-complement width of e_1/e_2 coefficients.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- k_sel  in  3  rank for this operation; legal values 2..KMAX; sampled with start.
- x  in  KMAX x N*COEF_W  polynomials for the u path.
- y  in  N*COEF_W  polynomial for the v path.
- msg_poly  in  N*COEF_W  decoded message polynomial.
- e_1  in  KMAX x N*E_W  signed noise for the u path.
- e_2  in  N*E_W  signed noise for the v path.
- u  out  KMAX x N*COEF_W  reduced results, registered.
- v  out  N*COEF_W  reduced result, registered.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when u and v are final.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- coef_err  out  1  sticky flag: some x/y/msg coefficient was >= Q.

Behaviour:
- Reset: state IDLE; u, v, busy, done, cfg_err, coef_err all 0; counters 0. Reset mid-operation aborts with no done pulse; outputs are zeroed.
- Inputs x, y, msg_poly, e_1, e_2 must be held stable from the start edge until done. They are not latched.
- FSM states: IDLE, RUN_U, RUN_V.
- IDLE:
  - start=1 with k_sel in 2..KMAX: latch k_sel, clear coef_err, set busy, go to RUN_U with poly index p=0 and beat b=0.
  - start=1 with an illegal k_sel: cfg_err=1 for one cycle, stay in IDLE.
- RUN_U: each cycle, lane j computes coefficient c = b*LANES+j as x[p][c] + sext(e_1[p][c]), reduced, and writes u[p][c].
  - At b = N/LANES-1: if p = k-1, go to RUN_V with b=0; otherwise increment p.
- RUN_V: lane j computes y[c] + sext(e_2[c]) + msg_poly[c], reduced, and writes v[c].
  - At the last beat, go to IDLE. On that same edge, clear busy and set done=1 for exactly one cycle.
- u[i] for i >= k are written to 0 at the start of the operation.
- Latency: done rises (k+1)*N/LANES edges after the start edge; for k=3, LANES=16 that is 64.
- start while busy is ignored.
- start is accepted in the cycle where done=1, because the FSM is already in IDLE. This gives back-to-back operation with no gap.
- Reduction on signed sum s, computed with COEF_W+2 bits:
  - if s < 0, add Q;
  - else if s >= 2Q, subtract 2Q;
  - else if s >= Q, subtract Q.
  - With in-range inputs the result is always in [0, Q-1].
- The significant range is bits [11:0]; the upper 4 container bits of each output coefficient are 0.
- coef_err is set when any x/y/msg operand consumed in a beat is >= Q. The out-of-range result is still written using the same correction and is not guaranteed to be < Q.

Decomposition:
- Package poly_add_pkg: Q, the derived beat count N/LANES, sum width, and the state enum typedef {IDLE, RUN_U, RUN_V}.
- Sub-module mod_add3: combinational per-lane unit taking a, b (unsigned COEF_W), e (signed E_W), c_en (selects whether the third operand is added). It outputs the reduced result and an out_of_range flag.
- Top instantiates LANES copies of mod_add3 via a generate loop. The top holds the FSM, the p/b counters, and the output slice writes.

Test Plan:
- k_sel=3, x[0][0]=3328, e_1[0][0]=+1, x[1][5]=0, e_1[1][5]=-2 -> u[0][0]=0, u[1][5]=3327, u[3] all 0; done pulse exactly 64 cycles after start; busy high for cycles 1..63.
- v path with y[7]=3000, e_2[7]=3, msg[7]=1665 -> v[7]=1339. With y=3328, e_2=7, msg=3328 -> 5 (2Q branch). With y=0, e_2=-8, msg=0 -> 3321.
- k_sel=4 followed by back-to-back start on the done cycle with k_sel=2 -> first done at 80 cycles, second done 48 cycles later; second run zeroes u[2] and u[3].
- k_sel=1, then k_sel=5 -> cfg_err pulses, busy stays 0, no done, outputs unchanged. A start asserted mid-run is ignored and the run completes normally.
- rst asserted at cycle 20 of a k=3 run -> next cycle: IDLE, u/v/busy/done=0, no done pulse. A subsequent start completes normally.
- x[2][100]=3329 -> coef_err set and held until the next accepted start; the other coefficients are still reduced correctly.
